// File: rtl/port_rx_pkg.sv
// Shared definitions for the port->GDMA receive packetizer.
//   rx_state_e : packetizer FSM states
//   lane_w()   : width of the lane index for a given OUT_W/IN_W ratio (min 1)
//   ratio_ok() : legality of an IN_W/OUT_W pairing, used by the top-level
//                elaboration check
package port_rx_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_LAST = 2'd2
    } rx_state_e;

    function automatic int lane_w(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

    function automatic bit ratio_ok(input int in_w, input int out_w);
        return (in_w > 0) && (out_w >= in_w) && ((out_w % in_w) == 0);
    endfunction

endpackage

// File: rtl/port_rx_out_reg.sv
// Single-entry valid/ready output register for the packetizer.
// Ports:
//   gdma_clk, rst_n      clock, async active-low reset
//   in_valid/in_ready    load handshake from the packer
//   in_data, in_last     packed word and its tlast flag
//   m_tvalid/m_tready    downstream handshake
//   m_tdata, m_tlast     registered outputs, held while stalled
module port_rx_out_reg
    import port_rx_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         gdma_clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tlast
);

    // Accept a new word whenever the slot is empty or being drained this cycle.
    assign in_ready = !m_tvalid || m_tready;

    always_ff @(posedge gdma_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (in_ready) begin
            m_tvalid <= in_valid;
            if (in_valid) begin
                m_tdata <= in_data;
                m_tlast <= in_last;
            end
        end
    end

endmodule

// File: rtl/port_rx_packetizer.sv
// Receive-side packetizer: narrow port words -> wide GDMA words with tlast.
// Strips HDR_WORDS leading words per packet when PORT_RX_PACKETIZER_HDR_STRIP_EN
// is defined (otherwise every word is payload), packs little-endian, zero-pads
// the final partial beat, and in sim mode counts and discards packets.
// Ports:
//   gdma_clk, rst_n            clock, async active-low reset
//   s_tvalid/s_tready/s_tdata  narrow input stream
//   m_tvalid/m_tready/m_tdata  wide output stream, m_tlast on final beat
//   mode_sim, pkt_len          per-packet config, latched on the first word
//   pkt_done, pkt_count        completion pulse and wrapping packet counter
//
// state  | meaning
// S_HDR  | dropping header words
// S_PAY  | packing payload words
// S_LAST | tlast beat pending, input stalled until it drains
module port_rx_packetizer
    import port_rx_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int LEN_W     = 8,
    parameter int HDR_WORDS = 1
) (
    input  logic             gdma_clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [IN_W-1:0]  s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [OUT_W-1:0] m_tdata,
    output logic             m_tlast,
    input  logic             mode_sim,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_count
);

    localparam int RATIO  = OUT_W / IN_W;
    localparam int LANE_W = lane_w(RATIO);
`ifdef PORT_RX_PACKETIZER_HDR_STRIP_EN
    localparam int HDR_N = HDR_WORDS;
`else
    localparam int HDR_N = 0;
`endif
    localparam rx_state_e S_START = (HDR_N == 0) ? S_PAY : S_HDR;

    if (!ratio_ok(IN_W, OUT_W) || HDR_WORDS < 0 || HDR_WORDS >= (1 << LEN_W)) begin : g_cfg_err
        $error("port_rx_packetizer: illegal IN_W/OUT_W/HDR_WORDS combination");
    end

    rx_state_e         state_q, state_d;
    logic              run_q;
    logic              in_pkt_q;
    logic              sim_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LANE_W-1:0] lane_q;
    logic [OUT_W-1:0]  pack_q, pack_n;

    logic             sim_e, streaming, out_ready, acc, is_end, hdr_word;
    logic             lane_full, store_word, ld_valid, tlast_hs, done_d;
    logic [LEN_W-1:0] len_e, cnt_n;

    // Config is live on the first word of a packet, latched copy afterwards.
    assign sim_e     = in_pkt_q ? sim_q : mode_sim;
    assign len_e     = in_pkt_q ? len_q : pkt_len;
    assign streaming = (len_e == '0);

    assign s_tready  = run_q && (state_q != S_LAST) && (sim_e || out_ready);
    assign acc       = s_tvalid && s_tready;
    assign cnt_n     = cnt_q + 1'b1;
    assign is_end    = !streaming && (cnt_n == len_e);
    // Unframed streaming never strips, even if the FSM is still in S_HDR.
    assign hdr_word  = (state_q == S_HDR) && !streaming;
    assign lane_full = (lane_q == LANE_W'(RATIO - 1));
    assign store_word = acc && !hdr_word && !sim_e;
    assign ld_valid  = store_word && (lane_full || is_end);
    assign tlast_hs  = m_tvalid && m_tready && m_tlast;
    assign done_d    = (acc && is_end && (hdr_word || sim_e)) || tlast_hs;

    always_comb begin
        pack_n = pack_q;
        pack_n[int'(lane_q)*IN_W +: IN_W] = s_tdata;
    end

    always_comb begin
        state_d = state_q;
        if (tlast_hs) begin
            state_d = S_START;
        end else if (acc) begin
            if (is_end)
                state_d = (hdr_word || sim_e) ? S_START : S_LAST;
            else if (hdr_word)
                state_d = (cnt_n == LEN_W'(HDR_N)) ? S_PAY : S_HDR;
            else if (state_q == S_HDR)
                state_d = S_PAY;
        end
    end

    always_ff @(posedge gdma_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_START;
        else        state_q <= state_d;
    end

    always_ff @(posedge gdma_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            in_pkt_q  <= 1'b0;
            sim_q     <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
            pkt_done  <= 1'b0;
            pkt_count <= '0;
        end else begin
            run_q    <= 1'b1;
            pkt_done <= done_d;
            if (done_d) pkt_count <= pkt_count + 1'b1;
            if (acc) begin
                if (!in_pkt_q) begin
                    sim_q <= mode_sim;
                    len_q <= pkt_len;
                end
                in_pkt_q <= !is_end;
                // Streaming holds the count at zero so it can never wrap.
                if (is_end)          cnt_q <= '0;
                else if (!streaming) cnt_q <= cnt_n;
            end
            if (store_word) begin
                if (ld_valid) begin
                    lane_q <= '0;
                    pack_q <= '0;
                end else begin
                    lane_q <= lane_q + 1'b1;
                    pack_q <= pack_n;
                end
            end
        end
    end

    port_rx_out_reg #(.W(OUT_W)) u_out_reg (
        .gdma_clk (gdma_clk),
        .rst_n    (rst_n),
        .in_valid (ld_valid),
        .in_ready (out_ready),
        .in_data  (pack_n),
        .in_last  (is_end),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast)
    );

endmodule

// File: tb/tb_port_rx_packetizer.sv
module tb_port_rx_packetizer;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int RATIO = OUT_W / IN_W;
`ifdef PORT_RX_PACKETIZER_HDR_STRIP_EN
    localparam int HDR_EFF = 1;
`else
    localparam int HDR_EFF = 0;
`endif

    logic              gdma_clk = 1'b0;
    logic              rst_n    = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [IN_W-1:0]   s_tdata  = '0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tlast;
    logic              mode_sim = 1'b0;
    logic [7:0]        pkt_len  = 8'd0;
    logic              pkt_done;
    logic [7:0]        pkt_count;

    port_rx_packetizer dut (
        .gdma_clk(gdma_clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .mode_sim(mode_sim), .pkt_len(pkt_len),
        .pkt_done(pkt_done), .pkt_count(pkt_count)
    );

    always #5 gdma_clk = ~gdma_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [OUT_W-1:0] d; logic l; } beat_t;
    beat_t            exp_q[$];
    logic [IN_W-1:0]  pbuf[$];
    logic [OUT_W-1:0] log_d[$];
    logic             log_l[$];
    bit               chk_en = 0;
    bit               in_pkt, lat_sim, last_pending, done_pending;
    int               lat_len, widx;
    logic [7:0]       mcount;
    int               n_done_seen = 0;

    task automatic model_clear();
        exp_q.delete(); pbuf.delete();
        in_pkt = 0; lat_sim = 0; lat_len = 0; widx = 0;
        last_pending = 0; done_pending = 0; mcount = 8'd0;
    endtask

    task automatic model_word(input logic [IN_W-1:0] d);
        bit is_end, hdr;
        logic [OUT_W-1:0] beat;
        if (!in_pkt) begin
            lat_len = int'(pkt_len); lat_sim = mode_sim; in_pkt = 1; widx = 0; pbuf.delete();
        end
        widx++;
        is_end = (lat_len != 0) && (widx == lat_len);
        hdr    = (lat_len != 0) && (widx <= HDR_EFF);
        if (!lat_sim && !hdr) begin
            pbuf.push_back(d);
            if (pbuf.size() == RATIO || is_end) begin
                beat = '0;
                for (int i = 0; i < pbuf.size(); i++) beat[i*IN_W +: IN_W] = pbuf[i];
                exp_q.push_back('{d: beat, l: is_end});
                pbuf.delete();
            end
        end
        if (is_end) begin
            in_pkt = 0;
            if (lat_sim || hdr) done_pending = 1;
            else                last_pending = 1;
        end
    endtask

    // Compare process: everything sampled mid-cycle, ahead of the next edge.
    always @(negedge gdma_clk) begin
        if (chk_en) begin
            bit exp_done, exp_rdy;
            exp_done = done_pending;
            done_pending = 0;
            if (exp_done) mcount = mcount + 8'd1;
            chk("pkt_done", 64'(pkt_done), 64'(exp_done));
            chk("pkt_count", 64'(pkt_count), 64'(mcount));
            if (pkt_done) n_done_seen++;
            exp_rdy = !last_pending && ((in_pkt ? lat_sim : mode_sim) || !m_tvalid || m_tready);
            chk("s_tready", 64'(s_tready), 64'(exp_rdy));
            chk("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() > 0));
            if (m_tvalid && exp_q.size() > 0) begin
                chk("m_tdata", 64'(m_tdata), 64'(exp_q[0].d));
                chk("m_tlast", 64'(m_tlast), 64'(exp_q[0].l));
                if (m_tready) begin
                    log_d.push_back(m_tdata); log_l.push_back(m_tlast);
                    if (exp_q[0].l) begin last_pending = 0; done_pending = 1; end
                    void'(exp_q.pop_front());
                end
            end
            if (s_tvalid && s_tready) model_word(s_tdata);
        end
    end

    // ---------------- drivers ----------------
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
    initial forever begin
        @(posedge gdma_clk); #2;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
    end

    logic [IN_W-1:0] wbuf[300];

    task automatic do_reset();
        chk_en = 0; s_tvalid = 1'b0; rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge gdma_clk);
        #1;
        chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst m_tdata", 64'(m_tdata), 64'd0);
        chk("rst m_tlast", 64'(m_tlast), 64'd0);
        chk("rst s_tready", 64'(s_tready), 64'd0);
        chk("rst pkt_done", 64'(pkt_done), 64'd0);
        chk("rst pkt_count", 64'(pkt_count), 64'd0);
        rst_n = 1'b1;
        @(posedge gdma_clk); #1;
        chk_en = 1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge gdma_clk); #1; end
    endtask

    task automatic send_word(input logic [IN_W-1:0] d);
        int n; bit ok;
        n = 0; ok = 0;
        s_tvalid = 1'b1; s_tdata = d;
        while (!ok) begin
            @(negedge gdma_clk); ok = (s_tready === 1'b1);
            @(posedge gdma_clk); #1;
            n++;
            if (!ok && n > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL send_word timeout: s_tready stuck low, expected high within 200 cycles");
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nw, input int len, input bit sim, input bit chg, input int gap);
        pkt_len = 8'(len); mode_sim = sim;
        for (int i = 0; i < nw; i++) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_word(wbuf[i]);
            if (i == 0 && chg) begin
                pkt_len  = 8'($urandom_range(1, 30));
                mode_sim = $urandom_range(0, 1) != 0;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || last_pending || done_pending) && n < 500) begin
            idle(1); n++;
        end
        if (n >= 500) begin
            n_cmp++; n_fail++;
            $display("FAIL drain timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        idle(3);
    endtask

    task automatic chk_beat(input int i, input logic [OUT_W-1:0] d, input logic l);
        if (i < log_d.size()) begin
            chk("log beat data", 64'(log_d[i]), 64'(d));
            chk("log beat last", 64'(log_l[i]), 64'(l));
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL log beat %0d missing: got none, expected 0x%0h", i, d);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        do_reset();

        // directed packet: len 5
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'h0001; wbuf[2] = 16'h0002; wbuf[3] = 16'h0003; wbuf[4] = 16'h0004;
        log_d.delete(); log_l.delete(); d0 = n_done_seen;
        send_pkt(5, 5, 0, 0, 0);
        wait_drain();
`ifdef PORT_RX_PACKETIZER_HDR_STRIP_EN
        chk("t1 nbeats", 64'(log_d.size()), 64'd2);
        chk_beat(0, 32'h00020001, 1'b0);
        chk_beat(1, 32'h00040003, 1'b1);
`else
        chk("t1 nbeats", 64'(log_d.size()), 64'd3);
        chk_beat(0, 32'h0001AAAA, 1'b0);
        chk_beat(1, 32'h00030002, 1'b0);
        chk_beat(2, 32'h00000004, 1'b1);
`endif
        chk("t1 done pulses", 64'(n_done_seen - d0), 64'd1);
        chk("t1 pkt_count", 64'(pkt_count), 64'd1);

        // directed packet: len 4, zero-padded tail
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'h1111; wbuf[2] = 16'h2222; wbuf[3] = 16'h3333;
        log_d.delete(); log_l.delete();
        send_pkt(4, 4, 0, 0, 0);
        wait_drain();
`ifdef PORT_RX_PACKETIZER_HDR_STRIP_EN
        chk_beat(0, 32'h22221111, 1'b0);
        chk_beat(1, 32'h00003333, 1'b1);
`else
        chk_beat(0, 32'h1111AAAA, 1'b0);
        chk_beat(1, 32'h33332222, 1'b1);
`endif
        chk("t2 pkt_count", 64'(pkt_count), 64'd2);

        // sim mode: 8 words counted, nothing emitted
        for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
        log_d.delete(); log_l.delete(); d0 = n_done_seen;
        send_pkt(8, 8, 1, 0, 0);
        mode_sim = 1'b0;
        wait_drain();
        chk("sim nbeats", 64'(log_d.size()), 64'd0);
        chk("sim done pulses", 64'(n_done_seen - d0), 64'd1);

        // output stall mid-packet
        for (int i = 0; i < 12; i++) wbuf[i] = 16'($urandom);
        fork
            send_pkt(12, 12, 0, 0, 0);
            begin
                idle(3);
                rdy_mode = 2;
                idle(9);
                chk("stall s_tready", 64'(s_tready), 64'd0);
                chk("stall m_tvalid", 64'(m_tvalid), 64'd1);
                rdy_mode = 0;
            end
        join
        wait_drain();

        // reset mid-packet, then a fresh packet
        for (int i = 0; i < 5; i++) wbuf[i] = 16'h5550 + 16'(i);
        send_pkt(3, 5, 0, 0, 0);
        do_reset();
        log_d.delete(); log_l.delete();
        wbuf[0] = 16'hBEEF; wbuf[1] = 16'h0A0A; wbuf[2] = 16'h0B0B; wbuf[3] = 16'h0C0C; wbuf[4] = 16'h0D0D;
        send_pkt(5, 5, 0, 0, 0);
        wait_drain();
`ifdef PORT_RX_PACKETIZER_HDR_STRIP_EN
        chk("rst nbeats", 64'(log_d.size()), 64'd2);
        chk_beat(0, 32'h0B0B0A0A, 1'b0);
        chk_beat(1, 32'h0D0D0C0C, 1'b1);
`else
        chk("rst nbeats", 64'(log_d.size()), 64'd3);
        chk_beat(0, 32'h0A0ABEEF, 1'b0);
        chk_beat(1, 32'h0C0C0B0B, 1'b0);
        chk_beat(2, 32'h00000D0D, 1'b1);
`endif
        chk("rst pkt_count", 64'(pkt_count), 64'd1);

        // randomized packets, random backpressure, mid-packet config changes
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) wbuf[i] = 16'($urandom);
            rdy_mode = $urandom_range(0, 1);
            send_pkt(len, len, $urandom_range(0, 3) == 0, 1, 2);
        end
        rdy_mode = 0;
        wait_drain();

        // 256 single-word packets: counter wraps
        do_reset();
        log_d.delete(); log_l.delete(); d0 = n_done_seen;
        for (int p = 0; p < 256; p++) begin
            wbuf[0] = 16'($urandom);
            send_pkt(1, 1, 0, 0, 0);
        end
        wait_drain();
        chk("wrap pkt_count", 64'(pkt_count), 64'd0);
        chk("wrap done pulses", 64'(n_done_seen - d0), 64'd256);
        chk("wrap nbeats", 64'(log_d.size()), 64'(HDR_EFF != 0 ? 0 : 256));

        // unframed streaming
        do_reset();
        log_d.delete(); log_l.delete(); d0 = n_done_seen;
        for (int i = 0; i < 7; i++) wbuf[i] = 16'($urandom);
        send_pkt(7, 0, 0, 0, 1);
        wait_drain();
        chk("stream nbeats", 64'(log_d.size()), 64'd3);
        chk_beat(0, {wbuf[1], wbuf[0]}, 1'b0);
        chk_beat(2, {wbuf[5], wbuf[4]}, 1'b0);
        chk("stream done pulses", 64'(n_done_seen - d0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/port_rx_packetizer.md
# port_rx_packetizer

Parametrised receive-side packetizer on the gdma_clk side of the port→GDMA path. It consumes narrow port words from the clock-crossing FIFO, strips a configurable header, and packs payload into wide GDMA words with tlast. It supports a sim/monitor mode that counts and discards packets, and reports per-packet completion. It generalises the fixed 16→32 converter plus length counter into one block with programmable widths, header size and packet length.

## Interface
- IN_W, 16, narrow port word width
- OUT_W, 32, GDMA word width; integer multiple of IN_W; RATIO = OUT_W/IN_W ≥ 1
- LEN_W, 8, width of packet-length field and counters
- HDR_WORDS, 1, leading narrow words per packet treated as header (0..2^LEN_W-1)
- gdma_clk  in  1  clock; all logic in this domain
- rst_n  in  1  reset, asynchronous, active-low
- s_tvalid / s_tready  in / out  1  narrow input handshake
- s_tdata  in  IN_W  narrow input data
- m_tvalid / m_tready  out / in  1  wide output handshake
- m_tdata  out  OUT_W  wide output data
- m_tlast  out  1  last beat of packet
- mode_sim  in  1  1 = count and discard, no output beats
- pkt_len  in  LEN_W  narrow words per packet, header included; 0 = unframed streaming
- pkt_done  out  1  one-cycle pulse per completed packet
- pkt_count  out  LEN_W  completed-packet counter, wraps

## Operation
- mode_sim and pkt_len are sampled on the first accepted word of each packet and held until the packet ends. Changes mid-packet are ignored.
- States:
  - S_HDR: accept and drop header words; go to S_PAY after HDR_WORDS.
  - S_PAY: pack payload.
  - S_LAST: final beat pending; s_tready=0 until the tlast beat handshakes, then go to S_HDR.
  - Enter S_PAY directly when HDR_WORDS=0.
- Packing is little-endian: the first payload word goes to m_tdata[IN_W-1:0], and the lane index increments per accepted word. After RATIO words, the packed word loads the output register.
- End of packet (word count = latched pkt_len):
  - A partial pack is zero-padded in the upper lanes.
  - The beat is emitted with m_tlast=1, and the block enters S_LAST.
  - The word counter and lane counter clear.
- pkt_len ≤ HDR_WORDS (nonzero): header-only packet. No output beat; pkt_done pulses; pkt_count increments.
- pkt_len = 0: no header strip, no tlast, pkt_done never pulses. Continuous packing.
- Sim mode:
  - s_tready=1 in every state except S_LAST, which is never entered in sim mode.
  - Words are counted, not stored; m_tvalid stays 0.
  - pkt_done pulses at packet end.
- pkt_count increments (mod 2^LEN_W) on every pkt_done.
- The word counter is LEN_W bits and never wraps within a packet, because the end is detected at equality.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, pkt_done=0, pkt_count=0. State = S_HDR (S_PAY if HDR_WORDS=0). All counters 0.
- s_tready asserts from the first cycle after reset deassertion.
- Normal mode: s_tready = (state≠S_LAST) && (!m_tvalid || m_tready). With m_tready held high, throughput is one narrow word per cycle.
- Latency: m_tvalid rises the cycle after the RATIO-th payload word, or after the packet's final word, is accepted.
- m_tdata and m_tlast are stable while m_tvalid && !m_tready.
- A simultaneous output drain and new pack load in the same cycle is legal: m_tvalid stays 1 with the new data.
- pkt_done, normal mode: pulses the cycle after the tlast handshake.
- pkt_done, sim mode and header-only packets: pulses the cycle after the last word is accepted.
- rst_n asserted mid-packet: the partial pack and any pending beat are discarded immediately, with no tlast.

## Configuration
- PORT_RX_PACKETIZER_HDR_STRIP_EN:
  - Defined: the first HDR_WORDS words are dropped as described above.
  - Undefined: S_HDR does not exist and HDR_WORDS is ignored. All pkt_len words are packed as payload, and a header-only packet cannot occur.

## Structure
- Package port_rx_pkg holds:
  - the state enum (S_HDR, S_PAY, S_LAST)
  - a ratio/lane-index width function (clog2)
  - an elaboration check that OUT_W % IN_W == 0
- One sub-module, port_rx_out_reg: a single-entry valid/ready output register holding m_tdata/m_tlast. The top level keeps the FSM, counters and lane packing.

## Test plan
- IN_W=16, OUT_W=32, HDR_WORDS=1, pkt_len=5; send 0xAAAA,0x0001,0x0002,0x0003,0x0004 → beats 0x00020001 (tlast=0), 0x00040003 (tlast=1); one pkt_done; pkt_count=1.
- pkt_len=4, HDR 1; send 0xAAAA,0x1111,0x2222,0x3333 → 0x22221111, then 0x00003333 with tlast=1 (zero-padded).
- mode_sim=1, pkt_len=8; send 8 words → m_tvalid never rises; s_tready constantly 1; pkt_done pulses once, one cycle after the 8th word.
- m_tready low for 10 cycles mid-packet → s_tready drops once a full pack is waiting; no data lost or reordered after release.
- Assert rst_n low after 3 of 5 words, then send a fresh 5-word packet → only the fresh packet appears; pkt_count=1.
- pkt_len=1, HDR 1 → no output beat; pkt_done pulses; 256 such packets → pkt_count wraps to 0 (LEN_W=8).
